// File: rtl/imem_load_ctrl.sv
// Instruction-memory access controller: shares the bank address bus between fetch and a byte-serial loader.
// Fetch latency 1 cycle, pipelined; loader writes in the accept cycle. Fetch is stalled (refused) while loading.
// Loader is backpressured only outside LOAD; ld_valid gaps simply pause the counters.
module imem_load_ctrl #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic [DEPTH_W:0]   load_len,
    input  logic               load_abort,
    input  logic               ld_valid,
    input  logic [7:0]         ld_byte,
    output logic               ld_ready,
    output logic               load_busy,
    output logic               load_done,
    output logic               load_err,
    input  logic               fetch_req,
    input  logic [31:0]        fetch_pc,
    output logic               fetch_valid,
    output logic [31:0]        fetch_instr,
    output logic               fetch_misalign,
    output logic               fetch_stall,
    output logic [DEPTH_W-1:0] bank_addr,
    output logic [3:0]         bank_we,
    output logic [7:0]         bank_wdata,
    input  logic [31:0]        bank_rdata
);

    typedef enum logic {IDLE, LOAD} state_t;

    localparam logic [DEPTH_W:0] MAX_LEN = {1'b1, {DEPTH_W{1'b0}}};

    state_t           state_q, state_d;
    logic [DEPTH_W:0] len_q, len_d;
    logic [DEPTH_W:0] word_q, word_d;
    logic [1:0]       lane_q, lane_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             fvalid_q, fvalid_d;
    logic [31:0]      finstr_q, finstr_d;
    logic             fmis_q, fmis_d;

    // Only the word-address bits of the PC select a bank entry; the rest wrap.
    logic unused_pc_hi;
    assign unused_pc_hi = ^fetch_pc[31:DEPTH_W+2];

    assign bank_wdata     = ld_byte;
    assign load_done      = done_q;
    assign load_err       = err_q;
    assign fetch_valid    = fvalid_q;
    assign fetch_instr    = finstr_q;
    assign fetch_misalign = fmis_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_d      = word_q;
        lane_d      = lane_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        fvalid_d    = 1'b0;
        finstr_d    = finstr_q;
        fmis_d      = fmis_q;
        ld_ready    = 1'b0;
        load_busy   = 1'b0;
        fetch_stall = 1'b0;
        bank_we     = 4'b0000;
        bank_addr   = fetch_pc[DEPTH_W+1:2];

        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    fvalid_d = 1'b1;
                    finstr_d = bank_rdata;
                    fmis_d   = |fetch_pc[1:0];
                end
                if (load_start) begin
                    if (load_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        len_d   = (load_len > MAX_LEN) ? MAX_LEN : load_len;
                        word_d  = '0;
                        lane_d  = 2'd0;
                    end
                end
            end
            LOAD: begin
                ld_ready    = 1'b1;
                load_busy   = 1'b1;
                fetch_stall = fetch_req;
                bank_addr   = word_q[DEPTH_W-1:0];
                if (ld_valid) begin
                    bank_we = 4'(1) << lane_q;
                    lane_d  = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        word_d = word_q + 1'b1;
                        if (word_q == len_q - 1'b1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                // Abort wins over a coincident completion; the accepted byte is still written.
                if (load_abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            word_q   <= '0;
            lane_q   <= 2'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fvalid_q <= 1'b0;
            finstr_q <= '0;
            fmis_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            word_q   <= word_d;
            lane_q   <= lane_d;
            done_q   <= done_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            finstr_q <= finstr_d;
            fmis_q   <= fmis_d;
        end
    end

endmodule
